div_clk_reset_sequencer: RTL and testbench

//  Reset sequencer for the divided-clock domain. It sits directly downstream of the

---
 rtl/div_clk_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_div_clk_reset_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_reset_sequencer.sv
// Reset sequencer for the divided-clock domain. Synchronises the PLL/CCC
// lock, waits for it to hold, releases the core reset, waits for the core's
// init-done handshake and then releases the fabric reset. A lock loss or an
// init timeout sends the sequence back to the start.
module div_clk_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int INIT_TIMEOUT       = 65535,
  parameter int CNT_W              = 16
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       LOCK,
  input  logic       CORE_INIT_DONE,
  input  logic       LOCK_LOST_CLR,
  output logic       CORE_RST_N,
  output logic       FABRIC_RST_N,
  output logic       READY,
  output logic       FAULT,
  output logic       LOCK_LOST,
  output logic [3:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_CORE      = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lost_set;

  // Lock synchroniser: LOCK is asynchronous to CLK_IN.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its neighbour, which is what turns this into a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], LOCK};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state and shared cycle counter.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_set = 1'b0;
    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          // This cycle already counts as the first locked cycle.
          state_d = S_STABLE;
          cnt_d   = CNT_ONE;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CORE: begin
        if (!lock_s) begin
          state_d  = S_WAIT_LOCK;
          cnt_d    = '0;
          lost_set = 1'b1;
        end else if ((cnt_q >= GAP_LAST) && CORE_INIT_DONE) begin
          // An early init-done simply waits here until the gap has elapsed.
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d  = S_WAIT_LOCK;
          lost_set = 1'b1;
        end
      end
      S_FAULT: begin
        // Lock loss is ignored here: the resets are already held.
        if (cnt_q == GAP_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State register and registered outputs decoded from the state being entered.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= '0;
      CORE_RST_N   <= 1'b0;
      FABRIC_RST_N <= 1'b0;
      READY        <= 1'b0;
      FAULT        <= 1'b0;
      LOCK_LOST    <= 1'b0;
      RETRY_CNT    <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      CORE_RST_N   <= (state_d == S_CORE) || (state_d == S_RUN);
      FABRIC_RST_N <= (state_d == S_RUN);
      READY        <= (state_d == S_RUN);
      FAULT        <= (state_d == S_FAULT);
      // A new loss wins over a clear arriving in the same cycle.
      LOCK_LOST    <= lost_set | (LOCK_LOST & ~LOCK_LOST_CLR);
      if ((state_d == S_FAULT) && (state_q != S_FAULT) && (RETRY_CNT != 4'hF)) begin
        RETRY_CNT <= RETRY_CNT + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_div_clk_reset_sequencer.sv
// Self-checking bench for div_clk_reset_sequencer: directed sequences plus a
// randomized soak, checked by a behavioural model through a scoreboard queue.
module tb_div_clk_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LSC  = 8;
  localparam int GAP  = 4;
  localparam int TMO  = 20;
  localparam int CW   = 16;

  logic       CLK_IN;
  logic       RST_N;
  logic       LOCK;
  logic       CORE_INIT_DONE;
  logic       LOCK_LOST_CLR;
  logic       CORE_RST_N;
  logic       FABRIC_RST_N;
  logic       READY;
  logic       FAULT;
  logic       LOCK_LOST;
  logic [3:0] RETRY_CNT;

  div_clk_reset_sequencer #(
    .SYNC_STAGES       (SYNC),
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP         (GAP),
    .INIT_TIMEOUT      (TMO),
    .CNT_W             (CW)
  ) dut (
    .CLK_IN        (CLK_IN),
    .RST_N         (RST_N),
    .LOCK          (LOCK),
    .CORE_INIT_DONE(CORE_INIT_DONE),
    .LOCK_LOST_CLR (LOCK_LOST_CLR),
    .CORE_RST_N    (CORE_RST_N),
    .FABRIC_RST_N  (FABRIC_RST_N),
    .READY         (READY),
    .FAULT         (FAULT),
    .LOCK_LOST     (LOCK_LOST),
    .RETRY_CNT     (RETRY_CNT)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output bundle: {core, fabric, ready, fault, lost, retry}.
  typedef struct packed {
    logic       core;
    logic       fabric;
    logic       ready;
    logic       fault;
    logic       lost;
    logic [3:0] retry;
  } exp_t;

  exp_t sb_q[$];

  // Behavioural model, described in terms of elapsed time in each phase.
  typedef enum {IDLE, COUNTING, CORE_UP, RUNNING, HOLD} phase_e;
  phase_e m_phase;
  bit     hist[SYNC];
  int     run_len, core_age, hold_age, m_retry;
  bit     m_lost;

  always @(posedge CLK_IN or negedge RST_N) begin
    bit   ls;
    bit   lost_evt;
    exp_t e;
    if (!RST_N) begin
      m_phase  = IDLE;
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      run_len  = 0;
      core_age = 0;
      hold_age = 0;
      m_retry  = 0;
      m_lost   = 1'b0;
      sb_q.delete();
      sb_q.push_back('0);
    end else begin
      // Lock as seen through SYNC flops: the sample taken SYNC edges ago.
      ls = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = LOCK;
      lost_evt = 1'b0;
      case (m_phase)
        IDLE: if (ls) begin
          run_len = 1;
          m_phase = COUNTING;
        end
        COUNTING: begin
          if (!ls) m_phase = IDLE;
          else begin
            run_len++;
            if (run_len == LSC) begin
              m_phase  = CORE_UP;
              core_age = 0;
            end
          end
        end
        CORE_UP: begin
          core_age++;
          if (!ls) begin
            m_phase  = IDLE;
            lost_evt = 1'b1;
          end else if (core_age >= GAP && CORE_INIT_DONE) begin
            m_phase = RUNNING;
          end else if (core_age == TMO) begin
            m_phase  = HOLD;
            hold_age = 0;
            if (m_retry < 15) m_retry++;
          end
        end
        RUNNING: if (!ls) begin
          m_phase  = IDLE;
          lost_evt = 1'b1;
        end
        HOLD: begin
          hold_age++;
          if (hold_age == GAP) m_phase = IDLE;
        end
        default: m_phase = IDLE;
      endcase
      if (lost_evt) m_lost = 1'b1;
      else if (LOCK_LOST_CLR) m_lost = 1'b0;
      e.core   = (m_phase == CORE_UP) || (m_phase == RUNNING);
      e.fabric = (m_phase == RUNNING);
      e.ready  = (m_phase == RUNNING);
      e.fault  = (m_phase == HOLD);
      e.lost   = m_lost;
      e.retry  = 4'(m_retry);
      sb_q.push_back(e);
    end
  end

  // Monitor: compare the DUT against the queued expectation every cycle.
  always @(negedge CLK_IN) begin
    exp_t act;
    exp_t e;
    if (mon_en) begin
      act = {CORE_RST_N, FABRIC_RST_N, READY, FAULT, LOCK_LOST, RETRY_CNT};
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(act), 32'h1ff);
      end else begin
        e = sb_q.pop_front();
        check("scoreboard", 32'(act), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  // Wait for a named output to reach a level; returns edges taken, -1 on timeout.
  task automatic wait_for(input int sel, input logic lvl, input int bound, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      case (sel)
        0: v = CORE_RST_N;
        1: v = FABRIC_RST_N;
        2: v = FAULT;
        default: v = READY;
      endcase
      if (v === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  int n, n2, fault_len;

  initial begin
    RST_N          = 1'b0;
    LOCK           = 1'b0;
    CORE_INIT_DONE = 1'b0;
    LOCK_LOST_CLR  = 1'b0;
    @(posedge CLK_IN);
    mon_en = 1'b1;
    #1;
    tick();
    check("reset_outputs", 32'({CORE_RST_N, FABRIC_RST_N, READY, FAULT, LOCK_LOST, RETRY_CNT}), 32'd0);

    // T1: lock up from t0 with init-done tied high.
    CORE_INIT_DONE = 1'b1;
    RST_N = 1'b1;
    LOCK  = 1'b1;
    wait_for(0, 1'b1, 50, n);
    check("t1_core_edge", 32'(n), 32'd10);
    wait_for(1, 1'b1, 50, n2);
    check("t1_fabric_edge", 32'(n + n2), 32'd14);
    check("t1_ready", 32'(READY), 32'd1);

    // T4: lock loss in S_RUN, then clear, then clear coincident with loss.
    LOCK = 1'b0;
    tick(); tick(); tick();
    check("t4_resets_low", 32'({CORE_RST_N, FABRIC_RST_N, READY}), 32'd0);
    check("t4_lost_set", 32'(LOCK_LOST), 32'd1);
    LOCK_LOST_CLR = 1'b1;
    tick();
    LOCK_LOST_CLR = 1'b0;
    check("t4_lost_clr", 32'(LOCK_LOST), 32'd0);
    LOCK = 1'b1;
    wait_for(3, 1'b1, 100, n);
    check("t4_relock_timeout", 32'(n > 0), 32'd1);
    LOCK = 1'b0;
    tick(); tick();
    LOCK_LOST_CLR = 1'b1;
    tick();
    LOCK_LOST_CLR = 1'b0;
    check("t4_set_beats_clr", 32'(LOCK_LOST), 32'd1);
    LOCK_LOST_CLR = 1'b1;
    tick();
    LOCK_LOST_CLR = 1'b0;

    // T2: a one-cycle lock glitch mid-count restarts the stable count.
    repeat (5) tick();
    LOCK = 1'b1;
    repeat (6) tick();
    LOCK = 1'b0;
    tick();
    LOCK = 1'b1;
    wait_for(0, 1'b1, 50, n);
    check("t2_core_edge", 32'(n + 7), 32'd17);
    check("t2_lost_clear", 32'(LOCK_LOST), 32'd0);

    // T3: init never completes -> repeated timeouts, retry count saturates.
    LOCK = 1'b0;
    CORE_INIT_DONE = 1'b0;
    repeat (5) tick();
    LOCK = 1'b1;
    wait_for(2, 1'b1, 200, n);
    check("t3_fault_seen", 32'(n > 0), 32'd1);
    check("t3_retry_one", 32'(RETRY_CNT), 32'd1);
    wait_for(2, 1'b0, 50, fault_len);
    check("t3_fault_len", 32'(fault_len), 32'd4);
    for (int f = 0; f < 16; f++) begin
      wait_for(2, 1'b1, 200, n);
      if (n < 0) check("t3_fault_timeout", 32'(f), 32'd16);
      wait_for(2, 1'b0, 50, n);
    end
    check("t3_retry_sat", 32'(RETRY_CNT), 32'd15);

    // T5: asynchronous reset in S_CORE, then a clean restart.
    LOCK = 1'b0;
    repeat (5) tick();
    LOCK = 1'b1;
    wait_for(0, 1'b1, 50, n);
    tick(); tick();
    RST_N = 1'b0;
    #1;
    check("t5_async_reset", 32'({CORE_RST_N, FABRIC_RST_N, READY, FAULT, LOCK_LOST, RETRY_CNT}), 32'd0);
    repeat (3) tick();
    RST_N = 1'b1;
    CORE_INIT_DONE = 1'b1;
    wait_for(0, 1'b1, 50, n);
    check("t5_restart_core_edge", 32'(n), 32'd10);

    // Randomized soak: lock mostly high with dropouts, random init-done and clears.
    for (int c = 0; c < 3000; c++) begin
      if (LOCK) begin
        if ($urandom_range(0, 199) < 3) LOCK = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        LOCK = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) CORE_INIT_DONE = ~CORE_INIT_DONE;
      LOCK_LOST_CLR = ($urandom_range(0, 31) == 0);
      tick();
    end
    LOCK_LOST_CLR = 1'b0;
    tick();
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
